mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer. Accepts two N_WORDS*W-bit operands through a valid/ready handshake.
- Performs the operation over N_WORDS cycles through a single W-bit slice adder, one word per cycle, chaining the carry in a register.
- Presents the full-width result, carry-out and signed overflow through an output valid/ready handshake.
- Lets wide arithmetic (128-bit default) share one 32-bit adder datapath instead of instantiating a full-width adder.

Parameters:
- W, 32, slice width in bits (width of the shared adder).
- N_WORDS, 4, number of slices; operand width is N_WORDS*W. Legal range is N_WORDS >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept an operand.
- op_sub  in  1  0 = a+b+cin; 1 = a-b (computed as a+~b+1, cin ignored).
- a  in  N_WORDS*W  operand A.
- b  in  N_WORDS*W  operand B.
- cin  in  1  carry-in, used for add only.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  N_WORDS*W  result.
- cout  out  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  out  1  two's-complement overflow of the full-width result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE.
  - in_ready=1; out_valid=0; busy=0.
  - sum=0, cout=0, ovf=0.
  - Word index=0, carry register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture a, b (b stored inverted if op_sub), the initial carry (op_sub ? 1 : cin), idx=0; go to RUN.
  - With in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0.
  - Each cycle the slice adder computes a[idx], b'[idx] and the carry register. The edge writes the sum slice into sum[idx*W +: W], updates the carry register, and increments idx.
  - On the edge where idx==N_WORDS-1: latch cout = final carry; latch ovf = (a_msb == b'_msb) && (sum_msb != a_msb); go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable until an edge with out_ready=1. That edge returns the block to IDLE and drops out_valid.
  - in_ready=0 throughout DONE; no same-cycle accept.
- Latency:
  - out_valid first high exactly N_WORDS cycles after the accepting edge.
  - Minimum initiation interval is N_WORDS+2 cycles with out_ready held at 1.
- Input rules:
  - in_valid while in_ready=0 is ignored and does not corrupt state.
  - Operands are sampled only on the accepting edge; later changes to a, b, op_sub or cin have no effect.
- sum is only valid while out_valid=1. During RUN, partially written slices may be visible.
- Wrap-around: the result is modulo 2^(N_WORDS*W); the carry is reported only via cout.
- Reset during RUN or DONE: the operation is aborted and all outputs return to reset values immediately. After release the block is in IDLE and no stale result is presented.

Decomposition:
- Package mp_add_pkg:
  - State enum (IDLE, RUN, DONE).
  - Default W / N_WORDS constants.
  - Function for idx width, clog2(N_WORDS).
- Sub-module mp_add_slice: purely combinational W-bit full adder (inputs x, y, ci; outputs s, co). Structure is free: ripple, carry-select or lookahead.
- The sequencer instantiates exactly one mp_add_slice.

Test Plan (W=32, N_WORDS=4):
1. Cross-word carry: a=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, cin=0, add → sum=128'h0000_0001_0000_0000_0000_0000_0000_0000, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
2. Full wrap-around: a=all ones, b=0, cin=1 → sum=0, cout=1, ovf=0.
3. Subtract with borrow: op_sub=1, a=5, b=7 → sum=128'hFFFF_..._FFFE, cout=0, ovf=0. Repeat with a=7, b=5 → sum=2, cout=1.
4. Signed overflow: a=128'h7FFF_..._FFFF, b=1, add → sum=128'h8000_..._0000, ovf=1, cout=0.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new operands → sum, cout and ovf stay stable, in_ready=0, new operands are not taken. Raise out_ready → IDLE the next cycle, then the next op is accepted and computed correctly.
6. Reset mid-operation: assert rst_n=0 while idx=2 → out_valid=0, sum=0 and busy=0 immediately. After release, in_ready=1 and a fresh op (a=3, b=4) gives sum=7.

Source files
------------

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and constants for the multi-precision add/subtract
// sequencer.
//   state_t      sequencer states (IDLE, RUN, DONE)
//   W_DEF        default slice width in bits
//   N_WORDS_DEF  default number of slices
//   idx_w()      width of the word index for a given slice count
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned W_DEF       = 32;
  localparam int unsigned N_WORDS_DEF = 4;

  // The minimum of 1 keeps the index a real vector even in degenerate builds.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mp_add_slice.sv
// mp_add_slice: purely combinational W-bit full adder shared by all words of
// a multi-precision operation.
//   x, y  in   W-bit addends
//   ci    in   carry in
//   s     out  W-bit sum
//   co    out  carry out of the slice MSB
module mp_add_slice #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract over N_WORDS cycles through one
// W-bit slice adder, carry chained through a register.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, op_sub, cin)
//   out_valid / out_ready result handshake (sum, cout, ovf)
//   busy                  high while an operation is running or held
//
// state | meaning
// IDLE  | ready for operands (in_ready=1)
// RUN   | one word per cycle through the slice adder, idx = word
// DONE  | result held with out_valid=1 until out_ready
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned N_WORDS = N_WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [N_WORDS*W-1:0] a,
  input  logic [N_WORDS*W-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_WORDS*W-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 busy
);

  localparam int unsigned    IW   = idx_w(N_WORDS);
  localparam logic [IW-1:0]  LAST = IW'(N_WORDS - 1);

  state_t                    state;
  logic [N_WORDS-1:0][W-1:0] a_q;
  logic [N_WORDS-1:0][W-1:0] b_q;   // already inverted for subtract
  logic [N_WORDS-1:0][W-1:0] sum_q;
  logic [IW-1:0]             idx;
  logic                      carry;

  logic [W-1:0]              slice_s;
  logic                      slice_co;

  mp_add_slice #(.W(W)) u_slice (
    .x  (a_q[idx]),
    .y  (b_q[idx]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  assign sum = sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= op_sub ? ~b : b;
            carry    <= op_sub ? 1'b1 : cin;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum_q[idx] <= slice_s;
          carry      <= slice_co;
          if (idx == LAST) begin
            cout <= slice_co;
            // Overflow from the operand sign bits as presented to the adder
            // (b already inverted for subtract) and the final sum sign bit.
            ovf       <= (a_q[N_WORDS-1][W-1] == b_q[N_WORDS-1][W-1]) &&
                         (slice_s[W-1] != a_q[N_WORDS-1][W-1]);
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed and randomized checks of mp_add_seq (W=32,
// N_WORDS=4) against a whole-number arithmetic reference model.
module tb_mp_add_seq;

  localparam int unsigned W  = 32;
  localparam int unsigned NW = 4;
  localparam int unsigned DW = W * NW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          op_sub = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] sum;
  logic          cout;
  logic          ovf;
  logic          busy;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_sum;
  logic          exp_cout;
  logic          exp_ovf;

  mp_add_seq #(.W(W), .N_WORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: plain wide arithmetic. Overflow is the exact signed result
  // falling outside the representable DW-bit two's-complement range.
  task automatic model(input logic [DW-1:0] ma, input logic [DW-1:0] mb,
                       input logic ms, input logic mc);
    logic [DW:0]          wide;
    logic signed [DW+1:0] sa, sb, r, lim;
    if (ms) begin
      exp_sum  = ma - mb;
      exp_cout = (ma >= mb);
    end else begin
      wide     = {1'b0, ma} + {1'b0, mb} + {{DW{1'b0}}, mc};
      exp_sum  = wide[DW-1:0];
      exp_cout = wide[DW];
    end
    sa  = $signed({{2{ma[DW-1]}}, ma});
    sb  = $signed({{2{mb[DW-1]}}, mb});
    r   = ms ? (sa - sb) : (sa + sb + $signed({{(DW+1){1'b0}}, mc}));
    lim = $signed({{(DW+1){1'b0}}, 1'b1}) <<< (DW - 1);
    exp_ovf = (r >= lim) || (r < -lim);
  endtask

  // Wait for in_ready, present one operand for one edge, update the model.
  task automatic start_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                          input logic ts, input logic tc, input string tag);
    int cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, ":ready"}, DW'(in_ready), DW'(1));
    a = ta; b = tb; op_sub = ts; cin = tc; in_valid = 1'b1;
    model(ta, tb, ts, tc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '1; b = '1; cin = ~tc; op_sub = ~ts;  // later changes must not matter
  endtask

  task automatic wait_result(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, ":latency"}, DW'(cyc), DW'(NW));
    chk({tag, ":sum"},  sum,        exp_sum);
    chk({tag, ":cout"}, DW'(cout),  DW'(exp_cout));
    chk({tag, ":ovf"},  DW'(ovf),   DW'(exp_ovf));
    chk({tag, ":busy"}, DW'(busy),  DW'(1));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ":ov_drop"}, DW'(out_valid), DW'(0));
    chk({tag, ":idle"},    DW'(in_ready),  DW'(1));
  endtask

  task automatic full_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                         input logic ts, input logic tc, input string tag);
    start_op(ta, tb, ts, tc, tag);
    wait_result(tag);
    drain(tag);
  endtask

  logic [DW-1:0] ra, rb;
  logic [DW-1:0] hold_sum;
  logic          hold_cout, hold_ovf;

  initial begin
    #12;
    chk("rst:in_ready",  DW'(in_ready),  DW'(1));
    chk("rst:out_valid", DW'(out_valid), DW'(0));
    chk("rst:busy",      DW'(busy),      DW'(0));
    chk("rst:sum",       sum,            '0);
    chk("rst:cout",      DW'(cout),      DW'(0));
    chk("rst:ovf",       DW'(ovf),       DW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    full_op(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0, "carry");
    chk("carry:const", exp_sum, 128'h0000_0001_0000_0000_0000_0000_0000_0000);
    full_op('1, '0, 1'b0, 1'b1, "wrap");
    full_op(128'd5, 128'd7, 1'b1, 1'b0, "sub_borrow");
    full_op(128'd7, 128'd5, 1'b1, 1'b1, "sub_ok");
    full_op({1'b0, {(DW-1){1'b1}}}, 128'd1, 1'b0, 1'b0, "sovf");
    full_op({1'b1, {(DW-1){1'b0}}}, 128'd1, 1'b1, 1'b0, "sovf_sub");

    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (i % 4 == 1) rb[DW-1] = ra[DW-1];
      full_op(ra, rb, 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    // Backpressure: result held, new operands ignored.
    start_op(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
             128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 1'b0, 1'b1, "bp");
    wait_result("bp");
    hold_sum = exp_sum; hold_cout = exp_cout; hold_ovf = exp_ovf;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk($sformatf("bp%0d:sum", i),  sum,            hold_sum);
      chk($sformatf("bp%0d:cout", i), DW'(cout),      DW'(hold_cout));
      chk($sformatf("bp%0d:ovf", i),  DW'(ovf),       DW'(hold_ovf));
      chk($sformatf("bp%0d:rdy", i),  DW'(in_ready),  DW'(0));
      chk($sformatf("bp%0d:ov", i),   DW'(out_valid), DW'(1));
    end
    in_valid = 1'b0;
    drain("bp");
    full_op(128'd100, 128'd23, 1'b1, 1'b0, "after_bp");

    // Reset in the middle of a run (idx==2 after two RUN edges).
    start_op(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd9, 1'b0, 1'b0, "rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid:busy_pre", DW'(busy), DW'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid:out_valid", DW'(out_valid), DW'(0));
    chk("rst_mid:sum",       sum,            '0);
    chk("rst_mid:busy",      DW'(busy),      DW'(0));
    chk("rst_mid:cout",      DW'(cout),      DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid:in_ready",  DW'(in_ready),  DW'(1));
    chk("rst_mid:no_stale",  DW'(out_valid), DW'(0));
    full_op(128'd3, 128'd4, 1'b0, 1'b0, "fresh");
    chk("fresh:const", exp_sum, 128'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
